// File: rtl/vga_pattern_gen.sv
// VGA raster timing plus a four-mode test-pattern generator (static square, bouncing square,
// colour bars, checkerboard). Every output is registered one clock after its raster position.
module vga_pattern_gen #(
    parameter int CORDW    = 10,
    parameter int CHW      = 8,
    parameter int G_H_RES  = 640,
    parameter int G_H_FP   = 16,
    parameter int G_H_SYNC = 96,
    parameter int G_H_BP   = 48,
    parameter int G_V_RES  = 480,
    parameter int G_V_FP   = 10,
    parameter int G_V_SYNC = 2,
    parameter int G_V_BP   = 33,
    parameter int SQ_SIZE  = 64,
    parameter int SPEED    = 2,
    parameter int BAR_W    = 80,
    parameter int CHK_LOG2 = 5,
    parameter logic [CHW-1:0] BG_R = CHW'('h11),
    parameter logic [CHW-1:0] BG_G = CHW'('h33),
    parameter logic [CHW-1:0] BG_B = CHW'('h77)
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [1:0]       i_mode,
    input  logic             i_pause,
    output logic [CORDW-1:0] sdl_sx,
    output logic [CORDW-1:0] sdl_sy,
    output logic             sdl_de,
    output logic [CHW-1:0]   sdl_r,
    output logic [CHW-1:0]   sdl_g,
    output logic [CHW-1:0]   sdl_b,
    output logic             o_h_sync,
    output logic             o_v_sync,
    output logic             o_frame
);

    localparam int H_TOTAL = G_H_RES + G_H_FP + G_H_SYNC + G_H_BP;
    localparam int V_TOTAL = G_V_RES + G_V_FP + G_V_SYNC + G_V_BP;

    localparam logic [CORDW-1:0] H_LAST = CORDW'(H_TOTAL - 1);
    localparam logic [CORDW-1:0] V_LAST = CORDW'(V_TOTAL - 1);
    localparam logic [CORDW-1:0] H_ACT  = CORDW'(G_H_RES);
    localparam logic [CORDW-1:0] V_ACT  = CORDW'(G_V_RES);
    localparam logic [CORDW-1:0] HS_BEG = CORDW'(G_H_RES + G_H_FP);
    localparam logic [CORDW-1:0] HS_END = CORDW'(G_H_RES + G_H_FP + G_H_SYNC);
    localparam logic [CORDW-1:0] VS_BEG = CORDW'(G_V_RES + G_V_FP);
    localparam logic [CORDW-1:0] VS_END = CORDW'(G_V_RES + G_V_FP + G_V_SYNC);

    // One extra bit so the right/bottom edge tests can never wrap.
    localparam logic [CORDW:0]   H_RES_W = (CORDW+1)'(G_H_RES);
    localparam logic [CORDW:0]   V_RES_W = (CORDW+1)'(G_V_RES);
    localparam logic [CORDW:0]   SQ_W    = (CORDW+1)'(SQ_SIZE);
    localparam logic [CORDW:0]   SPD_W   = (CORDW+1)'(SPEED);
    localparam logic [CORDW-1:0] SPD     = CORDW'(SPEED);
    localparam logic [CORDW-1:0] QX_MAX  = CORDW'(G_H_RES - SQ_SIZE);
    localparam logic [CORDW-1:0] QY_MAX  = CORDW'(G_V_RES - SQ_SIZE);

    localparam logic [CORDW-1:0] S0_X0 = CORDW'((G_H_RES - SQ_SIZE) / 2);
    localparam logic [CORDW-1:0] S0_X1 = CORDW'((G_H_RES - SQ_SIZE) / 2 + SQ_SIZE);
    localparam logic [CORDW-1:0] S0_Y0 = CORDW'((G_V_RES - SQ_SIZE) / 2);
    localparam logic [CORDW-1:0] S0_Y1 = CORDW'((G_V_RES - SQ_SIZE) / 2 + SQ_SIZE);

    localparam logic [CORDW-1:0] BAR_LAST = CORDW'(BAR_W - 1);
    localparam logic [CHW-1:0]   ONES     = '1;

    logic [CORDW-1:0] sx, sy;
    logic [CORDW-1:0] qx, qy, qx_n, qy_n;
    logic             dir_x, dir_y, dir_x_n, dir_y_n;  // 1 = moving toward 0
    logic [1:0]       mode_q;
    logic [CORDW-1:0] bar_cnt;
    logic [2:0]       bar_idx;

    logic             de, hs, vs, fr, frame_end, in_sq;
    logic [CHW-1:0]   pix_r, pix_g, pix_b;

    // Returns {new_dir, new_pos} for one axis of the bouncing square.
    function automatic logic [CORDW:0] bounce_step(
        input logic [CORDW-1:0] pos,
        input logic             dir,
        input logic [CORDW:0]   lim,
        input logic [CORDW-1:0] pmax
    );
        logic [CORDW:0] res;
        if (!dir) begin
            if ({1'b0, pos} + SQ_W + SPD_W > lim)
                res = {1'b1, pmax};
            else
                res = {1'b0, pos + SPD};
        end else begin
            if (pos < SPD)
                res = {1'b0, {CORDW{1'b0}}};
            else
                res = {1'b1, pos - SPD};
        end
        return res;
    endfunction

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sx <= '0;
            sy <= '0;
        end else if (sx == H_LAST) begin
            sx <= '0;
            sy <= (sy == V_LAST) ? '0 : sy + 1'b1;
        end else begin
            sx <= sx + 1'b1;
        end
    end

    always_comb begin
        de        = (sx < H_ACT) && (sy < V_ACT);
        hs        = !((sx >= HS_BEG) && (sx < HS_END));
        vs        = !((sy >= VS_BEG) && (sy < VS_END));
        fr        = (sx == '0) && (sy == '0);
        frame_end = (sx == H_LAST) && (sy == V_LAST);
    end

    always_comb begin
        qx_n    = qx;
        qy_n    = qy;
        dir_x_n = dir_x;
        dir_y_n = dir_y;
        if (frame_end && (mode_q == 2'd1) && !i_pause) begin
            {dir_x_n, qx_n} = bounce_step(qx, dir_x, H_RES_W, QX_MAX);
            {dir_y_n, qy_n} = bounce_step(qy, dir_y, V_RES_W, QY_MAX);
        end
    end

    // Mode is only sampled at the frame boundary so a frame is never drawn in two modes.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            qx     <= '0;
            qy     <= '0;
            dir_x  <= 1'b0;
            dir_y  <= 1'b0;
            mode_q <= 2'd0;
        end else begin
            qx    <= qx_n;
            qy    <= qy_n;
            dir_x <= dir_x_n;
            dir_y <= dir_y_n;
            if (frame_end)
                mode_q <= i_mode;
        end
    end

    // Bar tracker holds the bar index of the current sx; cleared on line wrap so sx==0 sees 0.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            bar_cnt <= '0;
            bar_idx <= '0;
        end else if (sx == H_LAST) begin
            bar_cnt <= '0;
            bar_idx <= '0;
        end else if (de) begin
            if (bar_cnt == BAR_LAST) begin
                bar_cnt <= '0;
                bar_idx <= bar_idx + 3'd1;
            end else begin
                bar_cnt <= bar_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        pix_r = '0;
        pix_g = '0;
        pix_b = '0;
        in_sq = 1'b0;
        if (de) begin
            case (mode_q)
                2'd0: begin
                    in_sq = (sx >= S0_X0) && (sx < S0_X1) && (sy >= S0_Y0) && (sy < S0_Y1);
                    pix_r = in_sq ? ONES : BG_R;
                    pix_g = in_sq ? ONES : BG_G;
                    pix_b = in_sq ? ONES : BG_B;
                end
                2'd1: begin
                    in_sq = (sx >= qx) && ({1'b0, sx} < {1'b0, qx} + SQ_W) &&
                            (sy >= qy) && ({1'b0, sy} < {1'b0, qy} + SQ_W);
                    pix_r = in_sq ? ONES : BG_R;
                    pix_g = in_sq ? ONES : BG_G;
                    pix_b = in_sq ? ONES : BG_B;
                end
                2'd2: begin
                    pix_r = {CHW{bar_idx[2]}};
                    pix_g = {CHW{bar_idx[1]}};
                    pix_b = {CHW{bar_idx[0]}};
                end
                default: begin
                    pix_r = {CHW{sx[CHK_LOG2] ^ sy[CHK_LOG2]}};
                    pix_g = pix_r;
                    pix_b = pix_r;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sdl_sx   <= '0;
            sdl_sy   <= '0;
            sdl_de   <= 1'b0;
            sdl_r    <= '0;
            sdl_g    <= '0;
            sdl_b    <= '0;
            o_h_sync <= 1'b1;
            o_v_sync <= 1'b1;
            o_frame  <= 1'b0;
        end else begin
            sdl_sx   <= sx;
            sdl_sy   <= sy;
            sdl_de   <= de;
            sdl_r    <= pix_r;
            sdl_g    <= pix_g;
            sdl_b    <= pix_b;
            o_h_sync <= hs;
            o_v_sync <= vs;
            o_frame  <= fr;
        end
    end

endmodule

// File: tb/tb_vga_pattern_gen.sv
// Directed bench for vga_pattern_gen on a shrunken 24x18 raster so whole frames stay cheap.
module tb_vga_pattern_gen;

    localparam int CORDW = 5;
    localparam int CHW   = 8;
    localparam int H_TOTAL = 24;
    localparam int V_TOTAL = 18;
    localparam int FRAME   = H_TOTAL * V_TOTAL;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [1:0]       mode = 2'd0;
    logic             pause = 1'b0;
    logic [CORDW-1:0] sdl_sx, sdl_sy;
    logic             sdl_de;
    logic [CHW-1:0]   sdl_r, sdl_g, sdl_b;
    logic             o_h_sync, o_v_sync, o_frame;

    vga_pattern_gen #(
        .CORDW(CORDW), .CHW(CHW),
        .G_H_RES(16), .G_H_FP(2), .G_H_SYNC(3), .G_H_BP(3),
        .G_V_RES(12), .G_V_FP(2), .G_V_SYNC(2), .G_V_BP(2),
        .SQ_SIZE(4), .SPEED(3), .BAR_W(2), .CHK_LOG2(2),
        .BG_R(8'h11), .BG_G(8'h33), .BG_B(8'h77)
    ) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_mode(mode), .i_pause(pause),
        .sdl_sx(sdl_sx), .sdl_sy(sdl_sy), .sdl_de(sdl_de),
        .sdl_r(sdl_r), .sdl_g(sdl_g), .sdl_b(sdl_b),
        .o_h_sync(o_h_sync), .o_v_sync(o_v_sync), .o_frame(o_frame)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_sx"}, int'(sdl_sx), 0);
        check({tag, "_sy"}, int'(sdl_sy), 0);
        check({tag, "_de"}, int'(sdl_de), 0);
        check({tag, "_rgb"}, int'({sdl_r, sdl_g, sdl_b}), 0);
        check({tag, "_hs"}, int'(o_h_sync), 1);
        check({tag, "_vs"}, int'(o_v_sync), 1);
        check({tag, "_frame"}, int'(o_frame), 0);
    endtask

    task automatic wait_pixel(input int x, input int y);
        int n = 0;
        while (!(int'(sdl_sx) == x && int'(sdl_sy) == y) && n < 2 * FRAME) begin
            @(negedge clk);
            n++;
        end
        check($sformatf("reach_%0d_%0d", x, y), (int'(sdl_sx) == x && int'(sdl_sy) == y) ? 1 : 0, 1);
    endtask

    task automatic wait_frame();
        int n = 0;
        @(negedge clk);
        while (!o_frame && n < 2 * FRAME) begin
            @(negedge clk);
            n++;
        end
        check("frame_pulse", int'(o_frame), 1);
    endtask

    // Scans the next frame's active area; first white pixel in raster order is the top-left.
    task automatic measure_square(output int qx, output int qy, output int cnt);
        bit found = 1'b0;
        qx = -1;
        qy = -1;
        cnt = 0;
        wait_frame();
        for (int i = 0; i < H_TOTAL * 12; i++) begin
            if (sdl_de && sdl_r == 8'hFF && sdl_g == 8'hFF && sdl_b == 8'hFF) begin
                if (!found) begin
                    qx = int'(sdl_sx);
                    qy = int'(sdl_sy);
                    found = 1'b1;
                end
                cnt++;
            end
            @(negedge clk);
        end
    endtask

    typedef struct {
        int md; int x; int y;
        int r; int g; int b; int de; int hs; int vs;
    } vec_t;

    localparam int NV = 29;
    vec_t vecs [NV];

    int exp_qx [12] = '{0, 3, 6, 9, 12, 12, 9, 6, 3, 0, 0, 3};
    int exp_qy [12] = '{0, 3, 6, 8, 5, 2, 0, 3, 6, 8, 5, 2};

    initial begin
        int cur_mode;
        int n, lo, hi;
        int mx, my, mc;

        vecs[0]  = '{0,  6,  4, 'hFF, 'hFF, 'hFF, 1, 1, 1};
        vecs[1]  = '{0,  5,  4, 'h11, 'h33, 'h77, 1, 1, 1};
        vecs[2]  = '{0,  7,  5, 'hFF, 'hFF, 'hFF, 1, 1, 1};
        vecs[3]  = '{0, 10,  5, 'h11, 'h33, 'h77, 1, 1, 1};
        vecs[4]  = '{0, 17,  5, 0, 0, 0, 0, 1, 1};
        vecs[5]  = '{0, 18,  5, 0, 0, 0, 0, 0, 1};
        vecs[6]  = '{0, 20,  5, 0, 0, 0, 0, 0, 1};
        vecs[7]  = '{0, 21,  5, 0, 0, 0, 0, 1, 1};
        vecs[8]  = '{0,  9,  7, 'hFF, 'hFF, 'hFF, 1, 1, 1};
        vecs[9]  = '{0,  9,  8, 'h11, 'h33, 'h77, 1, 1, 1};
        vecs[10] = '{0,  3, 13, 0, 0, 0, 0, 1, 1};
        vecs[11] = '{0,  3, 14, 0, 0, 0, 0, 1, 0};
        vecs[12] = '{0,  3, 16, 0, 0, 0, 0, 1, 1};
        vecs[13] = '{2,  0,  3, 0, 0, 0, 1, 1, 1};
        vecs[14] = '{2,  1,  3, 0, 0, 0, 1, 1, 1};
        vecs[15] = '{2,  2,  3, 0, 0, 'hFF, 1, 1, 1};
        vecs[16] = '{2,  5,  3, 0, 'hFF, 0, 1, 1, 1};
        vecs[17] = '{2,  8,  3, 'hFF, 0, 0, 1, 1, 1};
        vecs[18] = '{2, 13,  3, 'hFF, 'hFF, 0, 1, 1, 1};
        vecs[19] = '{2, 15,  3, 'hFF, 'hFF, 'hFF, 1, 1, 1};
        vecs[20] = '{2, 16,  3, 0, 0, 0, 0, 1, 1};
        vecs[21] = '{2,  0,  4, 0, 0, 0, 1, 1, 1};
        vecs[22] = '{3,  0,  0, 0, 0, 0, 1, 1, 1};
        vecs[23] = '{3,  4,  0, 'hFF, 'hFF, 'hFF, 1, 1, 1};
        vecs[24] = '{3,  4,  4, 0, 0, 0, 1, 1, 1};
        vecs[25] = '{3,  3,  5, 'hFF, 'hFF, 'hFF, 1, 1, 1};
        vecs[26] = '{3,  8,  8, 0, 0, 0, 1, 1, 1};
        vecs[27] = '{3, 12,  8, 'hFF, 'hFF, 'hFF, 1, 1, 1};
        vecs[28] = '{3, 15, 11, 'hFF, 'hFF, 'hFF, 1, 1, 1};

        repeat (3) @(negedge clk);
        check_reset_outputs("rst");
        rst_n = 1'b1;
        @(negedge clk);
        check("first_frame", int'(o_frame), 1);
        check("first_sx", int'(sdl_sx), 0);
        check("first_sy", int'(sdl_sy), 0);
        @(negedge clk);
        check("second_frame", int'(o_frame), 0);
        check("second_sx", int'(sdl_sx), 1);

        // Horizontal sync: position, width and period.
        n = 0;
        while (o_h_sync && n < 2 * H_TOTAL) begin @(negedge clk); n++; end
        check("hs_start_sx", int'(sdl_sx), 18);
        lo = 0;
        while (!o_h_sync && lo < 2 * H_TOTAL) begin @(negedge clk); lo++; end
        hi = 0;
        while (o_h_sync && hi < 2 * H_TOTAL) begin @(negedge clk); hi++; end
        check("hs_width", lo, 3);
        check("hs_period", lo + hi, H_TOTAL);

        // Vertical sync: starts at line 14, lasts two lines.
        n = 0;
        while (o_v_sync && n < 2 * FRAME) begin @(negedge clk); n++; end
        check("vs_start_sy", int'(sdl_sy), 14);
        check("vs_start_sx", int'(sdl_sx), 0);
        lo = 0;
        while (!o_v_sync && lo < 2 * FRAME) begin @(negedge clk); lo++; end
        check("vs_width", lo, 2 * H_TOTAL);

        cur_mode = 0;
        for (int i = 0; i < NV; i++) begin
            if (vecs[i].md != cur_mode) begin
                mode = 2'(vecs[i].md);
                cur_mode = vecs[i].md;
                wait_frame();
            end
            wait_pixel(vecs[i].x, vecs[i].y);
            check($sformatf("v%0d_r", i), int'(sdl_r), vecs[i].r);
            check($sformatf("v%0d_g", i), int'(sdl_g), vecs[i].g);
            check($sformatf("v%0d_b", i), int'(sdl_b), vecs[i].b);
            check($sformatf("v%0d_de", i), int'(sdl_de), vecs[i].de);
            check($sformatf("v%0d_hs", i), int'(o_h_sync), vecs[i].hs);
            check($sformatf("v%0d_vs", i), int'(o_v_sync), vecs[i].vs);
        end

        // Bouncing square: the first bounce frame still shows the reset position.
        mode = 2'd1;
        for (int f = 0; f < 12; f++) begin
            measure_square(mx, my, mc);
            check($sformatf("bounce%0d_qx", f), mx, exp_qx[f]);
            check($sformatf("bounce%0d_qy", f), my, exp_qy[f]);
            check($sformatf("bounce%0d_area", f), mc, 16);
        end

        pause = 1'b1;
        for (int f = 0; f < 3; f++) begin
            measure_square(mx, my, mc);
            check($sformatf("pause%0d_qx", f), mx, 3);
            check($sformatf("pause%0d_qy", f), my, 2);
        end
        pause = 1'b0;
        measure_square(mx, my, mc);
        check("resume_qx", mx, 6);
        check("resume_qy", my, 0);

        // Mode change mid-frame must not show bars until the next frame.
        wait_pixel(0, 6);
        mode = 2'd2;
        wait_pixel(2, 10);
        check("midswitch_old_r", int'(sdl_r), 'h11);
        check("midswitch_old_b", int'(sdl_b), 'h77);
        wait_frame();
        wait_pixel(2, 10);
        check("midswitch_new_r", int'(sdl_r), 0);
        check("midswitch_new_b", int'(sdl_b), 'hFF);
        wait_pixel(7, 10);
        check("midswitch_bar3", int'({sdl_r, sdl_g, sdl_b}), 'h00FFFF);

        // Asynchronous reset in the middle of a frame.
        wait_pixel(10, 5);
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("midrst");
        repeat (3) @(negedge clk);
        check_reset_outputs("midrst_hold");
        rst_n = 1'b1;
        @(negedge clk);
        check("rel_frame", int'(o_frame), 1);
        check("rel_sx", int'(sdl_sx), 0);
        check("rel_sy", int'(sdl_sy), 0);
        wait_pixel(7, 5);
        check("rel_mode0_rgb", int'({sdl_r, sdl_g, sdl_b}), 'hFFFFFF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
